tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_count_ctrl_pkg.sv | 17 +
 rtl/tff_cell.sv | 24 ++
 rtl/tff_count_ctrl.sv | 157 +++++++++++++++
 tb/tb_tff_count_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl_pkg
// Shared definitions for the T flip-flop counter controller.
//   state_t       : controller state encoding (IDLE, RUN, PAUSE)
//   DEFAULT_WIDTH : default number of T flip-flop cells in the counter bank
// ---------------------------------------------------------------------------
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// Single T flip-flop storage cell with an asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear (q -> 0)
//   T     : toggle enable, q inverts on the next rising edge when 1
//   q     : stored bit
// ---------------------------------------------------------------------------
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic T,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (T) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
// Start/stop controlled modulo-M up/down counter whose value lives only in a
// bank of WIDTH T flip-flop cells. The controller works out the desired next
// count and drives each cell with T = count XOR next.
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin counting (IDLE) or resume (PAUSE)
//   stop     : pause (RUN) or abort (PAUSE); wins over start
//   up       : direction, latched on start in IDLE (1 = up)
//   one_shot : latched on start in IDLE (1 = finish after one terminal count)
//   mod_val  : modulus, latched on start in IDLE (0 means 2**WIDTH)
//   count    : q outputs of the T flip-flop bank
//   busy     : state is not IDLE
//   wrap     : registered pulse on each continuous-mode wrap-around
//   done     : registered pulse when a one-shot run completes
// ---------------------------------------------------------------------------
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  state_t           r_state;
  logic             r_up;
  logic             r_one_shot;
  logic [WIDTH-1:0] r_mod;
  logic             r_wrap;
  logic             r_done;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_d;
  logic             w_done_d;
  logic             w_latch;
  logic [WIDTH-1:0] w_init;
  logic [WIDTH-1:0] w_term;
  logic             w_at_term;
  logic             w_go;

  // Modulus minus one also covers mod 0: it wraps to all-ones, i.e. 2**WIDTH-1.
  assign w_init    = r_up ? '0 : (r_mod - WIDTH'(1));
  assign w_term    = r_up ? (r_mod - WIDTH'(1)) : '0;
  assign w_at_term = (count == w_term);
  assign w_go      = start && !stop;

  // State register, configuration latch and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_up       <= 1'b0;
      r_one_shot <= 1'b0;
      r_mod      <= '0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wrap  <= w_wrap_d;
      r_done  <= w_done_d;
      if (w_latch) begin
        r_up       <= up;
        r_one_shot <= one_shot;
        r_mod      <= mod_val;
      end
    end
  end

  // Next-state logic; stop always beats start and beats terminal-count actions.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_go) w_state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          w_state_next = PAUSE;
        end else if (w_at_term && r_one_shot) begin
          w_state_next = IDLE;
        end
      end
      PAUSE: begin
        if (stop) begin
          w_state_next = IDLE;
        end else if (start) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: next count value, configuration latch and pulse requests.
  // The load in IDLE uses the live inputs because they are latched on the same edge.
  always_comb begin
    w_next   = count;
    w_wrap_d = 1'b0;
    w_done_d = 1'b0;
    w_latch  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_latch = 1'b1;
          w_next  = up ? '0 : (mod_val - WIDTH'(1));
        end
      end
      RUN: begin
        if (stop) begin
          w_next = count;
        end else if (w_at_term) begin
          if (r_one_shot) begin
            w_done_d = 1'b1;
          end else begin
            w_next   = w_init;
            w_wrap_d = 1'b1;
          end
        end else begin
          w_next = r_up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
      end
      PAUSE: begin
        if (stop) w_next = '0;
      end
      default: w_next = '0;
    endcase
  end

  // Each cell toggles exactly where the current and next values differ.
  assign w_t = count ^ w_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .T     (w_t[i]),
      .q     (count[i])
    );
  end

  assign busy = (r_state != IDLE);
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tff_count_ctrl
// Directed self-checking bench for tff_count_ctrl (WIDTH = 8). Inputs are
// driven and outputs sampled 1 ns after each rising edge; a background
// checker confirms every cycle that the T vector equals count XOR next count.
// ---------------------------------------------------------------------------
module tb_tff_count_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       stop;
  logic       up;
  logic       oneShot;
  logic [7:0] modVal;
  logic [7:0] count;
  logic       busy;
  logic       wrap;
  logic       done;

  int checks = 0;
  int errors = 0;

  tff_count_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .start    (start),
    .stop     (stop),
    .up       (up),
    .one_shot (oneShot),
    .mod_val  (modVal),
    .count    (count),
    .busy     (busy),
    .wrap     (wrap),
    .done     (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sets all control inputs at once.
  task automatic applyStimulus(input logic s, input logic p, input logic u,
                               input logic o, input logic [7:0] m);
    start   = s;
    stop    = p;
    up      = u;
    oneShot = o;
    modVal  = m;
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares all outputs against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [7:0] expCount,
                             input logic expBusy, input logic expWrap,
                             input logic expDone);
    checks++;
    assert ({count, busy, wrap, done} === {expCount, expBusy, expWrap, expDone})
    else begin
      errors++;
      $error("[TB] FAIL %s: count=%0d busy=%0b wrap=%0b done=%0b, expected count=%0d busy=%0b wrap=%0b done=%0b",
             tag, count, busy, wrap, done, expCount, expBusy, expWrap, expDone);
    end
  endtask

  // Every cycle the T vector seen before an edge must equal old XOR new count.
  logic [7:0] prevT;
  logic [7:0] prevCount;
  logic       prevValid = 1'b0;
  logic       tbRunning = 1'b1;

  always @(negedge clk) begin
    if (tbRunning && prevValid && rstN) begin
      checks++;
      assert (prevT === (prevCount ^ count))
      else begin
        errors++;
        $error("[TB] FAIL t_vector: T=%h, expected %h", prevT, prevCount ^ count);
      end
    end
    prevT     = dut.w_t;
    prevCount = count;
    prevValid = rstN;
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    #12;
    checkOutput("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;
    tick();
    checkOutput("first_idle", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 1: up, continuous, mod 5; start kept high in RUN is ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    tick();
    checkOutput("s1_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    tick(); checkOutput("s1_c1", 8'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s1_c2", 8'd2, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s1_c3", 8'd3, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s1_c4", 8'd4, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s1_wrap", 8'd0, 1'b1, 1'b1, 1'b0);
    tick(); checkOutput("s1_after", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("s1_pause", 8'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s1_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 2: down, one-shot, mod 3.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    tick(); checkOutput("s2_load", 8'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd9);
    tick(); checkOutput("s2_c1", 8'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s2_c0", 8'd0, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s2_done", 8'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("s2_idle", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 3: up, continuous, mod 10; pause at 6, resume, abort.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd10);
    tick(); checkOutput("s3_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("s3_at6", 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd10);
    tick(); checkOutput("s3_pause", 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    tick(); checkOutput("s3_hold", 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    tick(); checkOutput("s3_resume", 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("s3_c7", 8'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("s3_pause2", 8'd7, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s3_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 4a: mod 0 up rolls 255 -> 0 with a wrap pulse.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(); checkOutput("s4_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 254; i++) tick();
    checkOutput("s4_c254", 8'd254, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s4_c255", 8'd255, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("s4_wrap", 8'd0, 1'b1, 1'b1, 1'b0);
    tick(); checkOutput("s4_c1", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); tick();
    checkOutput("s4_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 4b: mod 0 down starts at all-ones.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("s4d_load", 8'd255, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("s4d_c254", 8'd254, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); tick();
    checkOutput("s4d_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Stop beats a one-shot terminal count; resume then finishes.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    tick(); checkOutput("pri_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    tick(); checkOutput("pri_term", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    tick(); checkOutput("pri_pause", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    tick(); checkOutput("pri_resume", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    tick(); checkOutput("pri_done", 8'd1, 1'b0, 1'b0, 1'b1);

    // Scenario 4c: mod 1 continuous wraps every cycle at 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    tick(); checkOutput("m1_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    tick(); checkOutput("m1_w1", 8'd0, 1'b1, 1'b1, 1'b0);
    tick(); checkOutput("m1_w2", 8'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    tick(); checkOutput("m1_pause", 8'd0, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("m1_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 4d: mod 1 one-shot finishes one cycle after RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(); checkOutput("m1o_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); checkOutput("m1o_done", 8'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("m1o_idle", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 5: start+stop in IDLE does nothing.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd10);
    tick(); checkOutput("s5_both", 8'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 5: asynchronous reset mid-run, between clock edges.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd10);
    tick(); checkOutput("s5_load", 8'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
    tick(); tick(); tick();
    checkOutput("s5_c3", 8'd3, 1'b1, 1'b0, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("s5_async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rstN = 1'b1;
    tick(); checkOutput("s5_noresume", 8'd0, 1'b0, 1'b0, 1'b0);
    tick(); checkOutput("s5_idle", 8'd0, 1'b0, 1'b0, 1'b0);

    tbRunning = 1'b0;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
